// File: rtl/vga_pkg.sv
// Shared VGA-side types: game-mode FSM states and the debounce length.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    OVER   = 2'd2
  } mode_state_t;

  localparam int DEBOUNCE_10MS = 650000;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus hold-time debounce for a bank of switches.
// r_cand doubles as the second synchroniser stage.
module sw_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = vga_pkg::DEBOUNCE_10MS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_stable;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta   <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_meta <= i_raw;
      if (r_meta != r_cand) begin
        r_cand <= r_meta;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/game_mode_fsm.sv
// Debounced switch-driven IDLE/ACTIVE/OVER screen selector, one-hot outputs.
// GAME_MODE_LOCK_EN: switch changes are ignored while ACTIVE.
module game_mode_fsm
  import vga_pkg::*;
#(
  parameter int N_MODES         = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int IDX_W           = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
  input  logic               clk65MHz,
  input  logic               rst,
  input  logic [15:0]        sw,
  input  logic               game_over,
  output logic               screen_idle,
  output logic [N_MODES-1:0] screen_mode,
  output logic               screen_over,
  output logic [IDX_W-1:0]   mode_idx,
  output logic               mode_change
);

  localparam logic [N_MODES-1:0] ONE = N_MODES'(1);

  logic [N_MODES-1:0] w_stable;
  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [4:0]         w_ones;
  logic [N_MODES-1:0] w_cur_onehot;
  mode_state_t        w_next;
  logic [IDX_W-1:0]   w_next_idx;
  logic               w_sw_unused;

  mode_state_t        r_state;
  logic [IDX_W-1:0]   r_mode_idx;
  logic               r_idle;
  logic [N_MODES-1:0] r_mode;
  logic               r_over;
  logic               r_change;

  assign w_sw_unused = ^sw;

  sw_debounce #(
    .WIDTH           (N_MODES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .i_clk    (clk65MHz),
    .i_rst    (rst),
    .i_raw    (sw[N_MODES-1:0]),
    .o_stable (w_stable)
  );

  always_comb begin
    w_sel_idx = '0;
    w_ones    = '0;
    for (int i = 0; i < N_MODES; i++) begin
      if (w_stable[i]) begin
        w_sel_idx = IDX_W'(i);
        w_ones    = w_ones + 5'd1;
      end
    end
    w_sel_valid = (w_ones == 5'd1);
  end

  assign w_cur_onehot = ONE << r_mode_idx;

  always_comb begin
    w_next     = r_state;
    w_next_idx = r_mode_idx;
    case (r_state)
      IDLE: begin
        if (w_sel_valid) begin
          w_next     = ACTIVE;
          w_next_idx = w_sel_idx;
        end
      end
      ACTIVE: begin
        if (game_over) begin
          w_next = OVER;
`ifndef GAME_MODE_LOCK_EN
        end else if (w_stable != w_cur_onehot) begin
          w_next = IDLE;
`endif
        end
      end
      OVER: begin
        // all switches released before the next game can arm
        if (w_stable == '0) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mode_idx <= '0;
      r_idle     <= 1'b1;
      r_mode     <= '0;
      r_over     <= 1'b0;
      r_change   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mode_idx <= w_next_idx;
      r_idle     <= (w_next == IDLE);
      r_mode     <= (w_next == ACTIVE) ? (ONE << w_next_idx) : '0;
      r_over     <= (w_next == OVER);
      r_change   <= (w_next != r_state);
    end
  end

  assign screen_idle = r_idle;
  assign screen_mode = r_mode;
  assign screen_over = r_over;
  assign mode_idx    = r_mode_idx;
  assign mode_change = r_change;

endmodule

// File: tb/tb_game_mode_fsm.sv
// Bench for game_mode_fsm: vector table, corner sequences, random vs model.
// Build with GAME_MODE_LOCK_EN to check the locked variant.
module tb_game_mode_fsm;

  localparam int NM = 2;
  localparam int DC = 4;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   sw;
  logic          go;
  logic          screen_idle;
  logic [NM-1:0] screen_mode;
  logic          screen_over;
  logic [IW-1:0] mode_idx;
  logic          mode_change;

  always #5 clk = ~clk;

  game_mode_fsm #(
    .N_MODES         (NM),
    .DEBOUNCE_CYCLES (DC),
    .IDX_W           (IW)
  ) dut (
    .clk65MHz    (clk),
    .rst         (rst),
    .sw          (sw),
    .game_over   (go),
    .screen_idle (screen_idle),
    .screen_mode (screen_mode),
    .screen_over (screen_over),
    .mode_idx    (mode_idx),
    .mode_change (mode_change)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: 0=idle 1=playing 2=game over; switch pattern accepted
  // once the same value was sampled DC+1 edges in a row.
  int            m_state;
  int            m_idx;
  logic [NM-1:0] m_stable;
  bit            m_change;
  logic [NM-1:0] m_hist[$];

  function automatic int popc(input logic [NM-1:0] v);
    int c = 0;
    for (int i = 0; i < NM; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int bitpos(input logic [NM-1:0] v);
    int p = 0;
    for (int i = 0; i < NM; i++) if (v[i]) p = i;
    return p;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_idx    = 0;
    m_stable = '0;
    m_change = 0;
    m_hist.delete();
    for (int i = 0; i <= DC; i++) m_hist.push_back('0);
  endtask

  task automatic model_step();
    int prev;
    bit same;
    if (rst) begin
      model_reset();
    end else begin
      prev = m_state;
      case (m_state)
        0: if (popc(m_stable) == 1) begin
          m_state = 1;
          m_idx   = bitpos(m_stable);
        end
        1: begin
          if (go) m_state = 2;
`ifndef GAME_MODE_LOCK_EN
          else if (m_stable != NM'(1 << m_idx)) m_state = 0;
`endif
        end
        default: if (m_stable == '0) m_state = 0;
      endcase
      m_change = (m_state != prev);
      same = 1;
      foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 0;
      if (same) m_stable = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(sw[NM-1:0]);
    end
  endtask

  task automatic tick();
    logic [NM-1:0] em;
    @(posedge clk);
    model_step();
    #1;
    em = (m_state == 1) ? NM'(1 << m_idx) : '0;
    check("model", {screen_idle, screen_mode, screen_over,
                    mode_idx, mode_change},
          {(m_state == 0), em, (m_state == 2), IW'(m_idx), m_change});
    check("onehot", 32'($onehot({screen_idle, screen_mode, screen_over})),
          32'd1);
  endtask

  typedef struct {
    bit          r;
    logic [15:0] s;
    bit          g;
    int          hold;
    bit          e_idle;
    logic [1:0]  e_mode;
    bit          e_over;
    bit          e_idx;
  } vec_t;

  vec_t tbl[$];
  int   found;
  int   t_idle;
  int   pulses;

  initial begin
    rst = 1'b1;
    sw  = '0;
    go  = 1'b0;
    model_reset();

    tbl.push_back('{1, 16'h0, 0,  2, 1, 2'b00, 0, 0});
    tbl.push_back('{0, 16'h1, 0,  6, 1, 2'b00, 0, 0});
    tbl.push_back('{0, 16'h1, 0,  1, 0, 2'b01, 0, 0});
    tbl.push_back('{0, 16'h1, 0,  5, 0, 2'b01, 0, 0});
    tbl.push_back('{0, 16'h1, 1,  1, 0, 2'b00, 1, 0});
    tbl.push_back('{0, 16'h0, 0,  7, 1, 2'b00, 0, 0});
    tbl.push_back('{0, 16'h2, 0,  7, 0, 2'b10, 0, 1});
    tbl.push_back('{0, 16'h2, 1,  1, 0, 2'b00, 1, 1});
    tbl.push_back('{0, 16'h2, 0, 10, 0, 2'b00, 1, 1});
    tbl.push_back('{0, 16'h0, 0,  7, 1, 2'b00, 0, 1});
    tbl.push_back('{0, 16'h3, 0, 20, 1, 2'b00, 0, 1});
    tbl.push_back('{0, 16'h0, 0, 10, 1, 2'b00, 0, 1});
    tbl.push_back('{0, 16'h1, 0,  3, 1, 2'b00, 0, 1});
    tbl.push_back('{0, 16'h0, 0, 10, 1, 2'b00, 0, 1});
    tbl.push_back('{0, 16'h0, 1,  1, 1, 2'b00, 0, 1});

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      sw  = tbl[i].s;
      go  = tbl[i].g;
      repeat (tbl[i].hold) tick();
      check($sformatf("vec%0d_idle", i), 32'(screen_idle), 32'(tbl[i].e_idle));
      check($sformatf("vec%0d_mode", i), 32'(screen_mode), 32'(tbl[i].e_mode));
      check($sformatf("vec%0d_over", i), 32'(screen_over), 32'(tbl[i].e_over));
      check($sformatf("vec%0d_idx", i), 32'(mode_idx), 32'(tbl[i].e_idx));
    end
    go = 1'b0;

    // reset in the middle of a debounce, then full latency from release
    sw = 16'h1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("rst_idle", 32'(screen_idle), 32'd1);
    check("rst_mode", 32'(screen_mode), 32'd0);
    check("rst_over", 32'(screen_over), 32'd0);
    check("rst_chg", 32'(mode_change), 32'd0);
    rst = 1'b0;
    found = 0;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (mode_change) pulses++;
      if (screen_mode == 2'b01) begin
        found = n;
        break;
      end
    end
    check("rst_latency", 32'(found), 32'd7);
    check("rst_pulses", 32'(pulses), 32'd1);

    // direct switch to another mode while playing
    sw = 16'h2;
`ifndef GAME_MODE_LOCK_EN
    found = 0;
    t_idle = 0;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (mode_change) pulses++;
      if (screen_idle && t_idle == 0) t_idle = n;
      if (screen_mode == 2'b10) begin
        found = n;
        break;
      end
    end
    check("m2m_idle_at", 32'(t_idle), 32'd7);
    check("m2m_mode_at", 32'(found), 32'd8);
    check("m2m_pulses", 32'(pulses), 32'd2);
`else
    repeat (30) tick();
    check("lock_mode", 32'(screen_mode), 32'h1);
    check("lock_idx", 32'(mode_idx), 32'd0);
`endif

    // game_over and release in the same cycle: game_over wins
    sw = 16'h0;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_over", 32'(screen_over), 32'd1);
    check("go_chg", 32'(mode_change), 32'd1);
    found = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (screen_idle) begin
        found = n;
        break;
      end
    end
    check("over_to_idle", 32'(found), 32'd6);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int div;
      div = ((i / 400) % 2 == 0) ? 12 : 2;
      rst = ($urandom_range(0, 499) == 0);
      go  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, div - 1) == 0) sw = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    go  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_mode_fsm.md
Name: game_mode_fsm

Overview:
Parametrised game-mode selector that replaces the fixed two-mode selector. It synchronises and debounces the lower N_MODES board switches and runs an IDLE/ACTIVE/OVER state machine. Outputs are registered one-hot screen selects for the VGA screen mux in the 65 MHz domain. It adds a game-over handshake and a release-before-rearm rule.

Parameters:
N_MODES, 2, number of playable modes; sw[N_MODES-1:0] select them; range 1..16.
DEBOUNCE_CYCLES, 650000, cycles a switch pattern must be stable before it is accepted (10 ms at 65 MHz); must be ≥1.
IDX_W, $clog2(N_MODES) (min 1), width of mode_idx.

Ports:
clk65MHz  in  1  system clock, 65 MHz
rst  in  1  reset, synchronous, active-high
sw  in  16  raw board switches; only [N_MODES-1:0] used
game_over  in  1  single-cycle pulse from game logic: current game finished
screen_idle  out  1  idle/menu screen selected
screen_mode  out  N_MODES  one-hot playable screen select
screen_over  out  1  game-over screen selected
mode_idx  out  IDX_W  binary index of active mode (held after leaving ACTIVE)
mode_change  out  1  one-cycle pulse on every state change

Behaviour:
- Interface (already decided): one clock, clk65MHz; reset rst is synchronous and active-high.
- Reset values: screen_idle=1, screen_mode=0, screen_over=0, mode_idx=0, mode_change=0, state=IDLE, synchroniser/debounce registers=0.
- Reset mid-operation: every register returns to its reset value on the next edge; no pending mode survives.
- Sync: 2-flop synchroniser on sw[N_MODES-1:0] gives sw_sync.
- Debounce: registers cand and cnt.
  - If sw_sync != cand: cand<=sw_sync, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: sw_stable<=cand.
  - Else cnt<=cnt+1.
  - cnt saturates and never wraps.
- Decode: sel_valid = sw_stable has exactly one bit set; sel_idx = its position.
  - Zero or multiple bits set means "no selection".
- FSM states (mode_state_t):
  - IDLE: sel_valid → ACTIVE, mode_idx<=sel_idx.
  - ACTIVE:
    - game_over → OVER.
    - Else sw_stable != onehot(mode_idx) → IDLE. This covers a change to another single bit: the FSM goes through IDLE and never jumps mode to mode.
  - OVER: sw_stable==0 → IDLE. Players must release all switches before re-arming.
- game_over in IDLE or OVER is ignored. game_over and a switch change in the same ACTIVE cycle: game_over wins.
- Outputs are registered (Moore):
  - IDLE: screen_idle=1.
  - ACTIVE: screen_mode=1<<mode_idx.
  - OVER: screen_over=1.
  - Exactly one of screen_idle, screen_over or a screen_mode bit is high every cycle.
- mode_change is high for exactly the first cycle the new outputs are valid.
- Latency: a clean sw edge to changed outputs takes exactly DEBOUNCE_CYCLES+3 clock edges (2 sync + DEBOUNCE_CYCLES debounce + 1 FSM). game_over to screen_over takes 1 edge.

Optional Feature:
GAME_MODE_LOCK_EN
- Defined: while ACTIVE, switch changes are ignored; only game_over leaves ACTIVE (→ OVER).
- Undefined: the ACTIVE→IDLE transition on switch change is as above.

Decomposition:
- vga_pkg gains:
  - typedef enum logic [1:0] mode_state_t {IDLE, ACTIVE, OVER};
  - localparam DEBOUNCE_10MS = 650000.
- One sub-module: sw_debounce (parameters WIDTH, DEBOUNCE_CYCLES; contains the synchroniser, cand/cnt and sw_stable). It is reusable for the button inputs.
- game_mode_fsm instantiates sw_debounce with WIDTH=N_MODES and contains the decode, FSM and output registers.

Test Plan:
(All with N_MODES=2, DEBOUNCE_CYCLES=4.)
1. Reset: assert rst for 2 edges mid-debounce with sw=01 → screen_idle=1, screen_mode=00, screen_over=0, mode_change=0. After release, screen_mode=01 appears exactly 7 edges after release.
2. From IDLE, sw=01 → exactly 7 edges later screen_mode=01, mode_idx=0, screen_idle=0, mode_change high 1 cycle. Same with sw=10 → screen_mode=10, mode_idx=1.
3. sw=11 held 20 cycles, then sw=00 → screen_idle stays 1, mode_change never pulses. A sw=01 glitch lasting 3 cycles → no state change.
4. ACTIVE (01), sw→10:
   - Undefined lock: IDLE after 7 edges, then screen_mode=10 one edge later, 2 mode_change pulses.
   - GAME_MODE_LOCK_EN: stays 01 indefinitely.
5. ACTIVE, game_over pulse together with sw→00 → next edge screen_over=1, mode_change pulse. Stays OVER until sw_stable==00, then screen_idle=1. game_over pulsed in IDLE → no effect.
6. Invariant checker, all scenarios: exactly one of screen_idle, screen_over or a screen_mode bit is high every cycle; error count must be 0.
